layer_engine: RTL and testbench

Parametrised fully-connected layer engine. It streams one input activation per handshake, fetches a `N_LANES`-wide weight word per activation from an external synchronous weight ROM, and accumulates `N_LANES` dot products in parallel. When all inputs have been consumed it requantises each accumulator (rounding shift, clamp) and emits the results serially over a valid/ready port. It replaces the fixed 28-neuron datapath/control pairing with one reusable layer block per network layer.

---
 rtl/layer_engine_if.sv | 42 ++++
 rtl/layer_engine.sv | 156 +++++++++++++++
 tb/tb_layer_engine.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_engine_if.sv
// layer_engine_if: bundles the activation stream, weight ROM port and result
// stream of one layer_engine.
//
// Handshake rule for both streams: a beat transfers on a rising clock edge
// where valid and ready are both high; the source holds data stable while
// valid is high and ready is low, and valid never waits on ready.
//
// Signals
//   in_valid/in_ready/in_data          activation stream into the engine
//   w_en/w_addr                        weight ROM read request (engine drives)
//   w_data                             weight word, one cycle after w_en
//   out_valid/out_ready/out_data/idx   result stream out of the engine
// Modports
//   slave  : the engine's view
//   master : the environment's view (source, ROM, sink)
interface layer_engine_if #(
  parameter int N_LANES = 28,
  parameter int DW      = 8,
  parameter int WADDR_W = 10,
  parameter int IDX_W   = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         in_data;
  logic                  w_en;
  logic [WADDR_W-1:0]    w_addr;
  logic [N_LANES*DW-1:0] w_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_data;
  logic [IDX_W-1:0]      out_idx;

  modport slave (
    input  in_valid, in_data, w_data, out_ready,
    output in_ready, w_en, w_addr, out_valid, out_data, out_idx
  );

  modport master (
    output in_valid, in_data, w_data, out_ready,
    input  in_ready, w_en, w_addr, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/layer_engine.sv
// layer_engine: fully-connected layer. Streams N_IN unsigned activations,
// fetches an N_LANES-wide signed weight word per activation, accumulates
// N_LANES dot products, then emits each requantised result serially.
//
// Build option: LAYER_ENGINE_RELU_EN
//   defined   -> results clamped to [0, 2^DW-1] (unsigned out_data)
//   undefined -> results clamped to [-2^(DW-1), 2^(DW-1)-1] (two's complement)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   start      one-cycle pulse, begins an inference when idle
//   busy       high outside IDLE
//   done       one-cycle pulse after the last result handshake
//   dbg_state  current FSM state (IDLE=0, RUN=1, DRAIN=2, EMIT=3)
//   bus        layer_engine_if.slave: activation, weight and result ports
module layer_engine #(
  parameter int N_LANES = 28,
  parameter int N_IN    = 784,
  parameter int DW      = 8,
  parameter int ACC_W   = 32,
  parameter int SHIFT   = 8,
  parameter int WADDR_W = $clog2(N_IN),
  parameter int IDX_W   = $clog2(N_LANES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state,
  layer_engine_if.slave       bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  localparam logic signed [ACC_W:0] ONE = {{ACC_W{1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] RND = ONE <<< (SHIFT - 1);
`ifdef LAYER_ENGINE_RELU_EN
  localparam logic signed [ACC_W:0] HI = (ONE <<< DW) - ONE;
  localparam logic signed [ACC_W:0] LO = '0;
`else
  localparam logic signed [ACC_W:0] HI = (ONE <<< (DW - 1)) - ONE;
  localparam logic signed [ACC_W:0] LO = -(ONE <<< (DW - 1));
`endif
  localparam logic [DW-1:0] HI_B = HI[DW-1:0];
  localparam logic [DW-1:0] LO_B = LO[DW-1:0];

  state_t                   state, state_next;
  logic [WADDR_W-1:0]       cnt;
  logic [IDX_W-1:0]         idx;
  logic [DW-1:0]            act_q;
  logic                     act_v;
  logic                     accept;
  logic                     emit_last;
  logic signed [ACC_W-1:0]  acc      [N_LANES];
  logic signed [ACC_W-1:0]  mac_next [N_LANES];
  logic signed [2*DW:0]     prod     [N_LANES];
  logic signed [ACC_W:0]    sel_ext, rsum, rq;

  assign dbg_state = state;
  assign accept    = (state == S_RUN) && bus.in_valid;
  assign emit_last = (state == S_EMIT) && bus.out_ready &&
                     (idx == IDX_W'(N_LANES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.w_en      = 1'b0;
    bus.w_addr    = '0;
    busy          = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        bus.in_ready = 1'b1;
        if (accept) begin
          bus.w_en   = 1'b1;
          bus.w_addr = cnt;
          if (cnt == WADDR_W'(N_IN - 1)) state_next = S_DRAIN;
        end
      end
      S_DRAIN: state_next = S_EMIT;
      S_EMIT: begin
        bus.out_valid = 1'b1;
        if (emit_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Activation is zero-extended by one bit so the signed multiply treats it
  // as unsigned; the product is then sign-extended into the accumulator.
  always_comb begin
    for (int k = 0; k < N_LANES; k++) begin
      prod[k]     = $signed({1'b0, act_q}) * $signed(bus.w_data[k*DW +: DW]);
      mac_next[k] = acc[k] + {{(ACC_W-2*DW-1){prod[k][2*DW]}}, prod[k]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      idx   <= '0;
      act_q <= '0;
      act_v <= 1'b0;
      done  <= 1'b0;
      for (int k = 0; k < N_LANES; k++) acc[k] <= '0;
    end else begin
      done  <= emit_last;
      act_v <= accept;
      if (accept) begin
        act_q <= bus.in_data;
        cnt   <= cnt + WADDR_W'(1);
      end
      if (state == S_IDLE && start) begin
        cnt <= '0;
        for (int k = 0; k < N_LANES; k++) acc[k] <= '0;
      end else if (act_v) begin
        for (int k = 0; k < N_LANES; k++) acc[k] <= mac_next[k];
      end
      if (state == S_DRAIN) idx <= '0;
      else if (state == S_EMIT && bus.out_ready)
        idx <= emit_last ? '0 : idx + IDX_W'(1);
    end
  end

  // Requantise one extra bit wide so the rounding add cannot overflow.
  always_comb begin
    sel_ext      = {acc[idx][ACC_W-1], acc[idx]};
    rsum         = sel_ext + RND;
    rq           = rsum >>> SHIFT;
    bus.out_data = '0;
    bus.out_idx  = '0;
    if (state == S_EMIT) begin
      bus.out_idx = idx;
      if (rq > HI)      bus.out_data = HI_B;
      else if (rq < LO) bus.out_data = LO_B;
      else              bus.out_data = rq[DW-1:0];
    end
  end

endmodule

// File: tb/tb_layer_engine.sv
module tb_layer_engine;
  localparam int N_LANES = 4;
  localparam int N_IN    = 3;
  localparam int DW      = 8;
  localparam int ACC_W   = 32;
  localparam int SHIFT   = 4;
  localparam int WADDR_W = 2;
  localparam int IDX_W   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [1:0] dbg_state;

  layer_engine_if #(.N_LANES(N_LANES), .DW(DW), .WADDR_W(WADDR_W), .IDX_W(IDX_W)) bus();

  layer_engine #(
    .N_LANES(N_LANES), .N_IN(N_IN), .DW(DW), .ACC_W(ACC_W), .SHIFT(SHIFT),
    .WADDR_W(WADDR_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .dbg_state(dbg_state), .bus(bus)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wen_count = 0;
  int wen_bad   = 0;

  logic [N_LANES*DW-1:0] w_mem [N_IN];
  int act [N_IN];
  int w_t [N_IN][N_LANES];
  logic [DW-1:0] exp_q [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.w_en) begin
      wen_count <= wen_count + 1;
      if (!bus.in_valid) wen_bad <= wen_bad + 1;
    end
  end

  // synchronous weight ROM
  always @(posedge clk) if (bus.w_en) bus.w_data <= w_mem[bus.w_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // reference model: dot product, round-half-up by 2^SHIFT, clamp
  function automatic logic [DW-1:0] ref_out(input int lane);
    longint s, r, lo, hi;
    logic [63:0] rv;
    s = 0;
    for (int i = 0; i < N_IN; i++) s += longint'(act[i]) * longint'(w_t[i][lane]);
    r = (s + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
`ifdef LAYER_ENGINE_RELU_EN
    lo = 0;   hi = (1 << DW) - 1;
`else
    lo = -(1 << (DW - 1)); hi = (1 << (DW - 1)) - 1;
`endif
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    rv = r;
    return rv[DW-1:0];
  endfunction

  task automatic set_basic(input int w0);
    act[0] = 16; act[1] = 32; act[2] = 48;
    for (int i = 0; i < N_IN; i++)
      for (int k = 0; k < N_LANES; k++) w_t[i][k] = 0;
    for (int i = 0; i < N_IN; i++) w_t[i][0] = w0;
    w_t[0][1] = 1;
  endtask

  task automatic set_uniform(input int a, input int w);
    for (int i = 0; i < N_IN; i++) begin
      act[i] = a;
      for (int k = 0; k < N_LANES; k++) w_t[i][k] = w;
    end
  endtask

  task automatic load_rom();
    logic [DW-1:0] b;
    for (int i = 0; i < N_IN; i++)
      for (int k = 0; k < N_LANES; k++) begin
        b = DW'(w_t[i][k]);
        w_mem[i][k*DW +: DW] = b;
      end
  endtask

  // driver: one complete inference with optional input gaps, output
  // backpressure at index 1 and a stray start pulse during RUN
  task automatic run_inference(input string name, input int gap, input int bp_len,
                               input bit mid_start);
    int k, guard, t_first, wen_before;
    logic [DW-1:0] hold_d, e;
    bit bp_done;
    load_rom();
    exp_q.delete();
    for (int l = 0; l < N_LANES; l++) exp_q.push_back(ref_out(l));
    wen_before = wen_count;
    bus.out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({name, "_busy_after_start"}, busy, 1);
    check({name, "_in_ready_run"}, bus.in_ready, 1);
    for (int i = 0; i < N_IN; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          #1 check({name, "_no_wen_gap"}, bus.w_en, 0);
          @(negedge clk);
        end
        if (mid_start && i == 1) begin
          bus.in_valid = 1'b0; start = 1'b1;
          @(negedge clk); start = 1'b0;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(act[i]);
      #1 check({name, "_w_en"}, bus.w_en, 1);
      check({name, "_w_addr"}, bus.w_addr, i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check({name, "_drain_in_ready"}, bus.in_ready, 0);
    check({name, "_drain_out_valid"}, bus.out_valid, 0);
    @(negedge clk);
    check({name, "_out_valid_latency"}, bus.out_valid, 1);
    t_first = cyc;
    k = 0; guard = 0; bp_done = 0;
    while (k < N_LANES && guard < 50) begin
      guard++;
      if (bus.out_valid) begin
        if (k == 1 && bp_len > 0 && !bp_done) begin
          bus.out_ready = 1'b0;
          hold_d = bus.out_data;
          for (int c = 0; c < bp_len; c++) begin
            @(negedge clk);
            check({name, "_bp_idx_hold"}, bus.out_idx, 1);
            check({name, "_bp_data_hold"}, bus.out_data, hold_d);
          end
          bp_done = 1;
          bus.out_ready = 1'b1;
        end
        e = exp_q.pop_front();
        check({name, "_out_idx"}, bus.out_idx, k);
        check($sformatf("%s_out_data%0d", name, k), bus.out_data, e);
        k++;
      end
      @(negedge clk);
    end
    if (k < N_LANES) check({name, "_emit_timeout"}, 0, 1);
    check({name, "_done"}, done, 1);
    check({name, "_busy_idle"}, busy, 0);
    if (bp_len == 0) check({name, "_done_timing"}, cyc - t_first, N_LANES);
    check({name, "_wen_count"}, wen_count - wen_before, N_IN);
    check({name, "_wen_bad"}, wen_bad, 0);
    @(negedge clk);
    check({name, "_done_pulse"}, done, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < N_IN; i++) w_mem[i] = '0;
    #12;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_w_en", bus.w_en, 0);
    check("rst_w_addr", bus.w_addr, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    set_basic(2);
    check("basic_ref0", ref_out(0), 12);
    check("basic_ref1", ref_out(1), 1);
    run_inference("basic", 0, 0, 0);

    set_basic(-2);
`ifdef LAYER_ENGINE_RELU_EN
    check("sign_ref0", ref_out(0), 8'h00);
`else
    check("sign_ref0", ref_out(0), 8'hF4);
`endif
    run_inference("sign", 0, 0, 0);

    set_uniform(255, 127);
`ifdef LAYER_ENGINE_RELU_EN
    check("sat_ref", ref_out(0), 255);
`else
    check("sat_ref", ref_out(0), 127);
`endif
    run_inference("sat_pos", 0, 0, 0);
    set_uniform(255, -128);
`ifndef LAYER_ENGINE_RELU_EN
    check("satneg_ref", ref_out(0), 8'h80);
`endif
    run_inference("sat_neg", 0, 0, 0);

    set_basic(2);
    run_inference("gaps", 2, 0, 0);
    run_inference("bp", 0, 5, 0);
    run_inference("mid_start", 0, 0, 1);

    // reset in the middle of RUN
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'd200;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_w_en", bus.w_en, 0);
    check("midrst_w_addr", bus.w_addr, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_out_idx", bus.out_idx, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    bus.in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    set_basic(2);
    run_inference("fresh", 0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N_IN; i++) begin
        act[i] = int'($urandom_range(0, 255));
        for (int k = 0; k < N_LANES; k++) w_t[i][k] = int'($urandom_range(0, 255)) - 128;
      end
      run_inference($sformatf("rand%0d", r), int'($urandom_range(0, 2)), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
